delay_buffer_r4sdf: RTL and testbench
=====================================

// Module: delay_buffer_r4sdf
// PURPOSE
//  Reorder buffer for a radix-4 SDF FFT stage: takes 4 complex samples per cycle (one matrix row),
//  then streams them out one complex sample per cycle in column-major (transposed) order.
//  A tail buffer preserves not-yet-read samples while the next frame overwrites storage.
//  One parameterisation replaces both the stage-1 and the stage-2 delay buffers (TEMP_DEPTH differs).
// PARAMETERS
//  WIDTH       32        signed width of each real/imag component
//  DEPTH       16        complex entries per frame; multiple of 4; ROWS = DEPTH/4
//  TEMP_DEPTH  DEPTH/2   tail-buffer entries; DEPTH/2 for stage 1, DEPTH/4 for stage 2
// PORTS
//  clock              in   1      single clock, rising edge
//  reset              in   1      asynchronous, active-low (0 = reset)
//  enable_write       in   1      write one row (4 complex samples)
//  enable_read_first  in   1      emit next sample from main storage
//  enable_read_last   in   1      emit next sample from tail buffer
//  rotate             in   1      frame boundary: restart read/tail/overlap sequencing
//  input_real_0..3    in   WIDTH  signed real parts, lane 0..3
//  input_imag_0..3    in   WIDTH  signed imag parts, lane 0..3
//  out_real           out  WIDTH  signed registered output, real
//  out_imag           out  WIDTH  signed registered output, imag
// BEHAVIOUR
//  - Reset (async, reset==0): mem, tail, out_real/out_imag <= 0; wrow, rptr, lptr, ovl <= 0.
//  - Storage: mem[0..DEPTH-1] re/im. Address of row r, lane j = 4*r + j.
//  - Write (enable_write): mem[4*wrow+j] <= input_j for j=0..3; wrow <= (wrow+1) mod ROWS.
//    Writes are independent of rotate and read enables.
//  - Column-major read address for position p: addr(p) = (p mod ROWS)*4 + (p / ROWS).
//  - Read first (enable_read_first && !enable_read_last): out <= mem[addr(rptr)]; rptr <= (rptr+1) mod DEPTH.
//    Reads use pre-edge contents (read-old-data on same-cycle write to the same address).
//  - Read last (enable_read_last): out <= tail[lptr]; lptr <= (lptr+1) mod TEMP_DEPTH.
//    enable_read_last has priority over enable_read_first.
//  - No read enable: out holds its value. Read latency: 1 clock (value valid after the enabling edge).
//  - Overlap snapshot: on the edge where enable_write && enable_read_first && ovl==0:
//    tail[k] <= mem[addr(DEPTH-TEMP_DEPTH+k)] (old contents) for k=0..TEMP_DEPTH-1; ovl <= 1.
//  - rotate (level, sampled each edge): rptr, lptr, ovl <= 0. A concurrent write is still performed.
//    wrow is not cleared by rotate; it wraps naturally after ROWS writes.
//  - Wrap-around:
//    - rptr past DEPTH-1 returns to position 0 (re-reads the current frame).
//    - lptr past TEMP_DEPTH-1 returns to 0.
//  - Frame sequence:
//    - ROWS writes; rotate.
//    - (DEPTH - TEMP_DEPTH - ROWS) read-first cycles.
//    - ROWS cycles of read-first + write (next frame; snapshot on the first of these).
//    - TEMP_DEPTH read-last cycles.
//  - reset asserted mid-frame: immediate clear; the frame is lost.
// TESTING (WIDTH=32, DEPTH=16; frame A row i=0..3: re=10(i+1)+j, im=5(i+1)+j)
//  1 Reset low -> out_real=out_imag=0, outputs stay 0 with no enables after release.
//  2 TEMP_DEPTH=8: write A (4 rows), rotate, 4 read-first -> re 10,20,30,40 / im 5,10,15,20.
//  3 TEMP_DEPTH=8: then 4 read+write of frame B (re=20(i+1)+j, im=10(i+1)+j) -> re 11,21,31,41;
//    8 read-last -> re 12,22,32,42,13,23,33,43 / im 7,12,17,22,8,13,18,23.
//  4 TEMP_DEPTH=4: write A, rotate, 8 read-first -> re 10,20,30,40,11,21,31,41;
//    4 read+write B -> 12,22,32,42; 4 read-last -> 13,23,33,43.
//  5 After scenario 4: rotate, 16 read-first -> frame B column-major: 20,40,60,80,21,...,83.
//  6 Assert reset mid read-last -> outputs 0 at once; read-first after release returns 0 (mem cleared).

Source files
------------

// File: rtl/delay_buffer_r4sdf_if.sv
`default_nettype none
// ============================================================================
// Interface   : delay_buffer_r4sdf_if
// Description : Row-write / sample-read bus of the radix-4 SDF delay buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface delay_buffer_r4sdf_if #(
    parameter int WIDTH = 32
);
    logic                    enable_write;
    logic                    enable_read_first;
    logic                    enable_read_last;
    logic                    rotate;
    logic signed [WIDTH-1:0] input_real_0;
    logic signed [WIDTH-1:0] input_real_1;
    logic signed [WIDTH-1:0] input_real_2;
    logic signed [WIDTH-1:0] input_real_3;
    logic signed [WIDTH-1:0] input_imag_0;
    logic signed [WIDTH-1:0] input_imag_1;
    logic signed [WIDTH-1:0] input_imag_2;
    logic signed [WIDTH-1:0] input_imag_3;
    logic signed [WIDTH-1:0] out_real;
    logic signed [WIDTH-1:0] out_imag;

    modport master (
        output enable_write, enable_read_first, enable_read_last, rotate,
        output input_real_0, input_real_1, input_real_2, input_real_3,
        output input_imag_0, input_imag_1, input_imag_2, input_imag_3,
        input  out_real, out_imag
    );

    modport slave (
        input  enable_write, enable_read_first, enable_read_last, rotate,
        input  input_real_0, input_real_1, input_real_2, input_real_3,
        input  input_imag_0, input_imag_1, input_imag_2, input_imag_3,
        output out_real, out_imag
    );
endinterface
`default_nettype wire

// File: rtl/delay_buffer_r4sdf.sv
`default_nettype none
// ============================================================================
// Module      : delay_buffer_r4sdf
// Description : Radix-4 SDF reorder buffer; 4-lane row writes, column-major
//               single-sample reads, tail buffer carrying the frame overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_buffer_r4sdf #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int TEMP_DEPTH = DEPTH / 2
) (
    input  logic                clock,
    input  logic                reset,
    delay_buffer_r4sdf_if.slave bus
);

    localparam int c_ROWS   = DEPTH / 4;
    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_WROW_W = (c_ROWS > 1) ? $clog2(c_ROWS) : 1;
    localparam int c_LPTR_W = (TEMP_DEPTH > 1) ? $clog2(TEMP_DEPTH) : 1;

    localparam logic [c_ADDR_W-1:0] c_RPTR_LAST = c_ADDR_W'(DEPTH - 1);
    localparam logic [c_WROW_W-1:0] c_WROW_LAST = c_WROW_W'(c_ROWS - 1);
    localparam logic [c_LPTR_W-1:0] c_LPTR_LAST = c_LPTR_W'(TEMP_DEPTH - 1);

    // Storage index of the sample at transposed (column-major) position pos.
    function automatic logic [c_ADDR_W-1:0] col_addr(input int pos);
        return c_ADDR_W'((pos % c_ROWS) * 4 + (pos / c_ROWS));
    endfunction

    logic signed [WIDTH-1:0] r_mem_re  [DEPTH];
    logic signed [WIDTH-1:0] r_mem_im  [DEPTH];
    logic signed [WIDTH-1:0] r_tail_re [TEMP_DEPTH];
    logic signed [WIDTH-1:0] r_tail_im [TEMP_DEPTH];

    logic [c_WROW_W-1:0]     r_wrow;
    logic [c_ADDR_W-1:0]     r_rptr;
    logic [c_LPTR_W-1:0]     r_lptr;
    logic                    r_ovl;
    logic signed [WIDTH-1:0] r_out_re;
    logic signed [WIDTH-1:0] r_out_im;

    logic signed [WIDTH-1:0] w_in_re [4];
    logic signed [WIDTH-1:0] w_in_im [4];
    logic [c_ADDR_W-1:0]     w_waddr [4];
    logic [c_ADDR_W-1:0]     w_raddr;
    logic                    w_rd_first;
    logic                    w_rd_last;
    logic                    w_snap;

    always_comb begin
        w_in_re[0] = bus.input_real_0;
        w_in_re[1] = bus.input_real_1;
        w_in_re[2] = bus.input_real_2;
        w_in_re[3] = bus.input_real_3;
        w_in_im[0] = bus.input_imag_0;
        w_in_im[1] = bus.input_imag_1;
        w_in_im[2] = bus.input_imag_2;
        w_in_im[3] = bus.input_imag_3;
        w_rd_last  = bus.enable_read_last;
        w_rd_first = bus.enable_read_first && !bus.enable_read_last;
        // First overlapped write of a frame freezes the unread tail.
        w_snap     = bus.enable_write && bus.enable_read_first && !r_ovl;
        w_raddr    = col_addr(int'(r_rptr));
        for (int j = 0; j < 4; j++) begin
            w_waddr[j] = c_ADDR_W'(int'(r_wrow) * 4 + j);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_re[i] <= '0;
                r_mem_im[i] <= '0;
            end
        end else if (bus.enable_write) begin
            for (int j = 0; j < 4; j++) begin
                r_mem_re[w_waddr[j]] <= w_in_re[j];
                r_mem_im[w_waddr[j]] <= w_in_im[j];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TEMP_DEPTH; k++) begin
                r_tail_re[k] <= '0;
                r_tail_im[k] <= '0;
            end
        end else if (w_snap) begin
            for (int k = 0; k < TEMP_DEPTH; k++) begin
                r_tail_re[k] <= r_mem_re[col_addr(DEPTH - TEMP_DEPTH + k)];
                r_tail_im[k] <= r_mem_im[col_addr(DEPTH - TEMP_DEPTH + k)];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrow <= '0;
            r_rptr <= '0;
            r_lptr <= '0;
            r_ovl  <= 1'b0;
        end else begin
            if (bus.enable_write) begin
                r_wrow <= (r_wrow == c_WROW_LAST) ? '0 : r_wrow + c_WROW_W'(1);
            end
            if (bus.rotate) begin
                r_rptr <= '0;
                r_lptr <= '0;
                r_ovl  <= 1'b0;
            end else begin
                if (w_rd_last) begin
                    r_lptr <= (r_lptr == c_LPTR_LAST) ? '0 : r_lptr + c_LPTR_W'(1);
                end else if (w_rd_first) begin
                    r_rptr <= (r_rptr == c_RPTR_LAST) ? '0 : r_rptr + c_ADDR_W'(1);
                end
                if (w_snap) begin
                    r_ovl <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_re <= '0;
            r_out_im <= '0;
        end else if (w_rd_last) begin
            r_out_re <= r_tail_re[r_lptr];
            r_out_im <= r_tail_im[r_lptr];
        end else if (w_rd_first) begin
            r_out_re <= r_mem_re[w_raddr];
            r_out_im <= r_mem_im[w_raddr];
        end
    end

    assign bus.out_real = r_out_re;
    assign bus.out_imag = r_out_im;

endmodule
`default_nettype wire

// File: tb/tb_delay_buffer_r4sdf.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_buffer_r4sdf
// Description : Scoreboard bench for two delay buffers (stage-1 and stage-2
//               tail depth) driven with identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_buffer_r4sdf;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic wr = 1'b0, rf = 1'b0, rl = 1'b0, rot = 1'b0;
    logic signed [31:0] in_re [4];
    logic signed [31:0] in_im [4];

    delay_buffer_r4sdf_if #(.WIDTH(32)) bus0 ();
    delay_buffer_r4sdf_if #(.WIDTH(32)) bus1 ();

    assign {bus0.enable_write, bus0.enable_read_first, bus0.enable_read_last, bus0.rotate} = {wr, rf, rl, rot};
    assign {bus0.input_real_0, bus0.input_real_1, bus0.input_real_2, bus0.input_real_3} = {in_re[0], in_re[1], in_re[2], in_re[3]};
    assign {bus0.input_imag_0, bus0.input_imag_1, bus0.input_imag_2, bus0.input_imag_3} = {in_im[0], in_im[1], in_im[2], in_im[3]};
    assign {bus1.enable_write, bus1.enable_read_first, bus1.enable_read_last, bus1.rotate} = {wr, rf, rl, rot};
    assign {bus1.input_real_0, bus1.input_real_1, bus1.input_real_2, bus1.input_real_3} = {in_re[0], in_re[1], in_re[2], in_re[3]};
    assign {bus1.input_imag_0, bus1.input_imag_1, bus1.input_imag_2, bus1.input_imag_3} = {in_im[0], in_im[1], in_im[2], in_im[3]};

    delay_buffer_r4sdf #(.WIDTH(32), .DEPTH(16), .TEMP_DEPTH(8)) u_dut_s1 (
        .clock(clk), .reset(rst_n), .bus(bus0));
    delay_buffer_r4sdf #(.WIDTH(32), .DEPTH(16), .TEMP_DEPTH(4)) u_dut_s2 (
        .clock(clk), .reset(rst_n), .bus(bus1));

    int errors = 0;
    int checks = 0;

    // Reference: frame held as a 4x4 matrix (row, lane); reads walk the transpose.
    logic signed [31:0] m_re [2][4][4];
    logic signed [31:0] m_im [2][4][4];
    logic signed [31:0] t_re [2][8];
    logic signed [31:0] t_im [2][8];
    int  wrow [2];
    int  rptr [2];
    int  lptr [2];
    bit  ovl  [2];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    function automatic int td(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got re=%0d im=%0d, expected re=%0d im=%0d at %0t", name,
                     $signed(act[63:32]), $signed(act[31:0]), $signed(exp[63:32]), $signed(exp[31:0]), $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 4; j++) begin
                    m_re[d][r][j] = 0;
                    m_im[d][r][j] = 0;
                end
            for (int k = 0; k < 8; k++) begin
                t_re[d][k] = 0;
                t_im[d][k] = 0;
            end
            wrow[d] = 0; rptr[d] = 0; lptr[d] = 0; ovl[d] = 0;
        end
    endtask

    task automatic model_step();
        logic [63:0] e;
        bit rd;
        int p;
        for (int d = 0; d < 2; d++) begin
            rd = 0;
            e  = '0;
            if (rl) begin
                e = {t_re[d][lptr[d]], t_im[d][lptr[d]]};
                rd = 1;
            end else if (rf) begin
                e = {m_re[d][rptr[d] % 4][rptr[d] / 4], m_im[d][rptr[d] % 4][rptr[d] / 4]};
                rd = 1;
            end
            if (wr && rf && !ovl[d]) begin
                for (int k = 0; k < td(d); k++) begin
                    p = 16 - td(d) + k;
                    t_re[d][k] = m_re[d][p % 4][p / 4];
                    t_im[d][k] = m_im[d][p % 4][p / 4];
                end
                ovl[d] = 1;
            end
            if (rl)      lptr[d] = (lptr[d] + 1) % td(d);
            else if (rf) rptr[d] = (rptr[d] + 1) % 16;
            if (rot) begin
                rptr[d] = 0; lptr[d] = 0; ovl[d] = 0;
            end
            if (wr) begin
                for (int j = 0; j < 4; j++) begin
                    m_re[d][wrow[d]][j] = in_re[j];
                    m_im[d][wrow[d]][j] = in_im[j];
                end
                wrow[d] = (wrow[d] + 1) % 4;
            end
            if (rd) begin
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    // kind: 0 = frame A row, 1 = frame B row, other = random data
    task automatic step(input bit w, input bit f, input bit l, input bit r,
                        input int kind = 2, input int row = 0);
        @(negedge clk);
        wr = w; rf = f; rl = l; rot = r;
        for (int j = 0; j < 4; j++) begin
            case (kind)
                0:       begin in_re[j] = 10 * (row + 1) + j; in_im[j] = 5 * (row + 1) + j;  end
                1:       begin in_re[j] = 20 * (row + 1) + j; in_im[j] = 10 * (row + 1) + j; end
                default: begin in_re[j] = $urandom;           in_im[j] = $urandom;           end
            endcase
        end
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    // Monitor: pops on every read edge, otherwise the output must hold.
    bit mon_rd;
    logic [63:0] last0 = '0, last1 = '0;
    always @(posedge clk) begin
        mon_rd = rf | rl;
        #1;
        if (!rst_n) begin
            last0 = '0;
            last1 = '0;
        end else begin
            if (mon_rd) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_underflow_s1: got empty queue, expected a pending read");
                end else last0 = q0.pop_front();
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_underflow_s2: got empty queue, expected a pending read");
                end else last1 = q1.pop_front();
            end
            check("out_s1", {bus0.out_real, bus0.out_imag}, last0);
            check("out_s2", {bus1.out_real, bus1.out_imag}, last1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int j = 0; j < 4; j++) begin
            in_re[j] = 0;
            in_im[j] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_s1", {bus0.out_real, bus0.out_imag}, 64'd0);
        check("reset_s2", {bus1.out_real, bus1.out_imag}, 64'd0);
        rst_n = 1'b1;
        idle(3);

        // Frame A, rotate, 4 read-first, 4 read+write B, 8 read-last
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, i);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, i);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        idle(1);
        check("last_tail_s1", {bus0.out_real, bus0.out_imag}, {32'sd43, 32'sd23});
        check("last_tail_s2", {bus1.out_real, bus1.out_imag}, {32'sd43, 32'sd23});
        idle(1);

        // Stage-2 frame sequence: 8 read-first, 4 read+write B, 4 read-last
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, i);
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, i);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        idle(1);
        check("s4_tail_s1", {bus0.out_real, bus0.out_imag}, {32'sd42, 32'sd22});
        check("s4_tail_s2", {bus1.out_real, bus1.out_imag}, {32'sd43, 32'sd23});

        // Re-read frame B column-major, then wrap past the end
        step(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
        idle(1);
        check("frameB_end_s1", {bus0.out_real, bus0.out_imag}, {32'sd83, 32'sd43});
        check("frameB_end_s2", {bus1.out_real, bus1.out_imag}, {32'sd83, 32'sd43});
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

        // Random mix of every control combination
        repeat (250) begin
            step($urandom_range(0, 1), $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 15) == 0);
        end
        idle(2);

        // Reset in the middle of a read-last burst
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        @(negedge clk);
        wr = 0; rf = 0; rl = 0; rot = 0;
        rst_n = 1'b0;
        #1;
        check("async_reset_s1", {bus0.out_real, bus0.out_imag}, 64'd0);
        check("async_reset_s2", {bus1.out_real, bus1.out_imag}, 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
